s_a_ctrl: RTL and testbench
===========================

# s_a_ctrl

Sequencer and two-port arbiter for the shared 4-bit serial adder (`s_a`). It accepts operand pairs from two requesters over valid/ready handshakes and grants the adder to one requester at a time. For each granted request it pulses the adder's reset to load the operands, then counts the adder's bit-serial latency. When the count completes it captures sum and carry and returns them with the requester ID. It sits between the requesting logic and one `s_a` instance, and owns that instance's `rst`, `a` and `b` inputs.

## Interface
Parameters:
- `W`, default 4: operand and sum width; must match the `s_a` instance.
- `LAT`, default 4: number of cycles after the load pulse until `s_a` outputs are final; legal range is 1..15.

Ports:
- `clk`, in, 1: the single clock; every register updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 2: bit i is asserted when requester i has an operand pair pending.
- `req_a0`, `req_b0`, in, W each: operands from requester 0.
- `req_a1`, `req_b1`, in, W each: operands from requester 1.
- `req_ready`, out, 2: bit i pulses high for one cycle when requester i's operands are accepted.
- `rsp_valid`, out, 1: a result is available.
- `rsp_ready`, in, 1: the consumer accepts the result.
- `rsp_id`, out, 1: which requester the result belongs to.
- `rsp_s`, out, W: captured sum.
- `rsp_c`, out, 1: captured carry.
- `sa_rst`, out, 1: drives `s_a.rst`.
- `sa_a`, `sa_b`, out, W each: drive `s_a.a` and `s_a.b`.
- `sa_s`, in, W: from `s_a.s`.
- `sa_c`, in, 1: from `s_a.c`.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- The controller has four states.
  - **IDLE:** if any `req_valid` bit is set, grant one requester (see the arbitration rule below). In the same cycle, assert `req_ready[g]`, latch that requester's operands into `op_a`/`op_b`, record `g` as the request ID, and go to LOAD. If no bit is set, stay in IDLE.
  - **LOAD:** assert `sa_rst` for exactly one cycle, then go to RUN with the counter cleared to 0.
  - **RUN:** increment the counter each cycle. When the counter equals LAT-1, capture `sa_s` and `sa_c` into `rsp_s`/`rsp_c`, set `rsp_valid`, and go to DONE.
  - **DONE:** hold `rsp_*`. When `rsp_valid && rsp_ready`, clear `rsp_valid` and go to IDLE.
- `sa_a` and `sa_b` always drive `op_a` and `op_b`. These registers change only on acceptance in IDLE, so the operands are stable through LOAD and RUN.
- `sa_rst` is high during reset and during LOAD, and low in every other state.
- `req_ready` is high only in the IDLE acceptance cycle, and only for the granted bit. It is never high for both bits at once.
- A requester may change its operands or drop `req_valid` at any time before it is accepted; nothing is latched until the acceptance cycle.
- Carry is not an overflow error: `rsp_c` carries bit W of a+b. The sum `rsp_s` is (a+b) mod 2^W.
- Results are returned in acceptance order. The block holds only one request at a time, with no queueing.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - `op_a` = `op_b` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_s` = 0, `rsp_c` = 0.
  - `req_ready` = 0, `busy` = 0, `sa_rst` = 1.
  - last-grant register = 1, so requester 0 wins the first contended grant.
- Latency, counting the acceptance cycle as cycle 0:
  - Cycle 1: LOAD, with `sa_rst` = 1.
  - Cycles 2 to LAT+1: RUN.
  - From cycle LAT+2: `rsp_valid` = 1.
- Minimum spacing between acceptances is LAT+3 cycles, reached when `rsp_ready` is held high.
- If `rsp_ready` is already high when `rsp_valid` first rises, the result is consumed in that same cycle, and the earliest next acceptance is the following cycle.
- Reset asserted mid-operation, in any state, aborts the transaction. The block enters the reset values on the next edge, the result is discarded, and no `req_ready` is produced for an aborted request.
- Requests stall for as long as `rsp_ready` stays low in DONE. This backpressure is unbounded.

## Configuration
- Macro `SA_CTRL_RR_EN` selects the arbitration rule.
- **Defined (round robin):** when both `req_valid` bits are set, grant the requester that is not the last granted one. The last-grant register updates on every acceptance. A single valid requester is always granted, regardless of history.
- **Undefined (fixed priority):** requester 0 always wins a tie. The last-grant register is not implemented.
- Port list and timing are identical in both builds.

## Test plan
- **Single request.** After reset release, requester 0 presents a=3, b=5, and `rsp_ready` is held at 1. Required: `req_ready` = 01 at cycle 0 and `sa_rst` high only at cycle 1. At cycle LAT+2 (6 for LAT=4): `rsp_valid` = 1, `rsp_id` = 0, `rsp_s` = 8, `rsp_c` = 0.
- **Wrap-around carry.** Requester 1 presents a=15, b=1. Required: `rsp_s` = 0, `rsp_c` = 1, `rsp_id` = 1. Also a=15, b=15 must give `rsp_s` = 14, `rsp_c` = 1.
- **Contention.** Both requesters stay valid for four transactions.
  - With `SA_CTRL_RR_EN`: grant IDs are 0, 1, 0, 1.
  - Without it: grant IDs are 0, 0, 0, 0.
- **Backpressure.** Hold `rsp_ready` = 0 for 10 cycles after `rsp_valid` rises. Required: `rsp_*` stays stable, `req_ready` stays 0, and `busy` stays 1. When `rsp_ready` rises, `rsp_valid` drops on the next edge.
- **Reset mid-run.** Assert `rst` in the second RUN cycle. Required: on the next edge `rsp_valid` = 0, `busy` = 0, `sa_rst` = 1, and no response appears for the aborted request. A fresh request afterwards completes with a correct sum.
- **Exhaustive sweep.** All 256 (a, b) pairs are sent from alternating requesters. Every `{rsp_c, rsp_s}` must equal a+b, and the adjacent spacing between acceptances must equal LAT+3 cycles.

Source files
------------

// File: rtl/s_a_ctrl.sv
// Sequencer/arbiter for one shared s_a serial adder: grants one of two requesters,
// pulses the adder load, waits LAT cycles and returns {carry, sum}. Define SA_CTRL_RR_EN for round robin.
module s_a_ctrl #(
    parameter int W   = 4,
    parameter int LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    output logic [1:0]   req_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_s,
    output logic         rsp_c,
    output logic         sa_rst,
    output logic [W-1:0] sa_a,
    output logic [W-1:0] sa_b,
    input  logic [W-1:0] sa_s,
    input  logic         sa_c,
    output logic         busy
);

    // state | meaning
    // IDLE  | waiting for a request; grants and latches operands on acceptance
    // LOAD  | one-cycle sa_rst pulse loads the adder
    // RUN   | counting adder latency, capture result at LAT-1
    // DONE  | holding result until rsp_ready
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

    state_t       state, state_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic [W-1:0] op_a, op_b;
    logic         grant_id;
    logic         accept;
    logic         capture;

`ifdef SA_CTRL_RR_EN
    logic last_grant;

    always_comb begin
        if (req_valid == 2'b11) grant_id = ~last_grant;
        else                    grant_id = ~req_valid[0];
    end
`else
    always_comb grant_id = ~req_valid[0];
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        req_ready = 2'b00;
        sa_rst    = rst;
        case (state)
            IDLE: begin
                // no grant is visible while reset is held, so an aborted cycle never handshakes
                if ((|req_valid) && !rst) begin
                    accept              = 1'b1;
                    req_ready[grant_id] = 1'b1;
                    state_nxt           = LOAD;
                end
            end
            LOAD: begin
                sa_rst    = 1'b1;
                cnt_nxt   = 4'd0;
                state_nxt = RUN;
            end
            RUN: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == CNT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_valid && rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_s     <= '0;
            rsp_c     <= 1'b0;
`ifdef SA_CTRL_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                op_a   <= grant_id ? req_a1 : req_a0;
                op_b   <= grant_id ? req_b1 : req_b0;
                rsp_id <= grant_id;
`ifdef SA_CTRL_RR_EN
                last_grant <= grant_id;
`endif
            end
            if (capture) begin
                rsp_s     <= sa_s;
                rsp_c     <= sa_c;
                rsp_valid <= 1'b1;
            end else if (state == DONE && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign sa_a = op_a;
    assign sa_b = op_b;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_s_a_ctrl.sv
// Self-checking bench for s_a_ctrl: directed table, contention, backpressure, reset abort,
// random traffic and an exhaustive operand sweep against a behavioural model.
module tb_s_a_ctrl;
    localparam int W   = 4;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]   req_ready;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_c;
    logic [W-1:0] rsp_s;
    logic         sa_rst;
    logic [W-1:0] sa_a, sa_b, sa_s;
    logic         sa_c;
    logic         busy;

    s_a_ctrl #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_c(rsp_c),
        .sa_rst(sa_rst), .sa_a(sa_a), .sa_b(sa_b), .sa_s(sa_s), .sa_c(sa_c),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // adder stand-in: garbage until LAT-1 edges after the load pulse, then a+b
    int           m_cnt = 0;
    logic [W:0]   m_junk = '0;
    logic [W:0]   m_out;
    always @(posedge clk) begin
        m_junk <= (W+1)'($urandom);
        if (sa_rst)         m_cnt <= LAT - 1;
        else if (m_cnt > 0) m_cnt <= m_cnt - 1;
    end
    always_comb begin
        m_out = m_junk;
        if (m_cnt == 0 && !sa_rst) m_out = {1'b0, sa_a} + {1'b0, sa_b};
    end
    assign sa_s = m_out[W-1:0];
    assign sa_c = m_out[W];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;
    int m_last = 1;
    int acc_cyc = 0;

    typedef struct {
        logic [1:0] v;
        int         a;
        int         b;
        int         hold;
        int         exp_sum;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        req_valid = 2'($urandom);
        req_a0 = W'($urandom); req_b0 = W'($urandom);
        req_a1 = W'($urandom); req_b1 = W'($urandom);
    endtask

    function automatic int model_grant(input logic [1:0] v);
        if (v == 2'b11) begin
`ifdef SA_CTRL_RR_EN
            return 1 - m_last;
`else
            return 0;
`endif
        end
        return v[0] ? 0 : 1;
    endfunction

    // one transaction from an IDLE sample point back to the next IDLE sample point
    task automatic txn(input logic [1:0] v, input int a0, input int b0, input int a1, input int b1,
                       input int exp_sum, input int hold, output int dut_id);
        int id, ea, eb, es, k;
        logic ok;
        logic [W-1:0] hs;
        logic hc, hid;
        id = model_grant(v);
        ea = id ? a1 : a0;
        eb = id ? b1 : b0;
        es = (exp_sum >= 0) ? exp_sum : ea + eb;
        req_valid = v;
        req_a0 = W'(a0); req_b0 = W'(b0); req_a1 = W'(a1); req_b1 = W'(b1);
        rsp_ready = (hold == 0);
        #1;
        k = 0;
        while (req_ready == 2'b00 && k < 40) begin
            tick();
            k++;
        end
        chk("req_ready", req_ready, 32'(1 << id));
        chk("accept_sa_rst", sa_rst, 0);
        acc_cyc = cyc;
        m_last = id;
        tick();
        scramble();
        #1;
        chk("load_sa_rst", sa_rst, 1);
        chk("load_busy", busy, 1);
        chk("load_req_ready", req_ready, 0);
        chk("sa_a", sa_a, ea);
        chk("sa_b", sa_b, eb);
        ok = 1'b1;
        for (int c = 0; c < LAT; c++) begin
            tick();
            scramble();
            #1;
            if (sa_rst !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1 ||
                int'(sa_a) != ea || int'(sa_b) != eb) ok = 1'b0;
        end
        chk("run_phase", ok, 1);
        tick();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_s", rsp_s, es % (1 << W));
        chk("rsp_c", rsp_c, (es >> W) & 1);
        dut_id = int'(rsp_id);
        hid = rsp_id; hs = rsp_s; hc = rsp_c;
        if (hold > 0) begin
            ok = 1'b1;
            for (int h = 1; h <= hold; h++) begin
                tick();
                scramble();
                #1;
                if (rsp_valid !== 1'b1 || rsp_s !== hs || rsp_c !== hc || rsp_id !== hid ||
                    req_ready !== 2'b00 || busy !== 1'b1) ok = 1'b0;
            end
            chk("backpressure_hold", ok, 1);
            rsp_ready = 1'b1;
        end
        tick();
        req_valid = 2'b00;
        chk("rsp_drop", rsp_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
        m_last = 1;
    endtask

    vec_t tbl[7];
    int   exp_seq[4];

    initial begin
        int id, prev, sp_ok, r;
        logic ok;
        tbl[0] = '{2'b01, 3, 5, 0, 8};
        tbl[1] = '{2'b10, 15, 1, 0, 16};
        tbl[2] = '{2'b10, 15, 15, 0, 30};
        tbl[3] = '{2'b01, 15, 15, 0, 30};
        tbl[4] = '{2'b01, 0, 0, 0, 0};
        tbl[5] = '{2'b10, 9, 9, 10, 18};
        tbl[6] = '{2'b01, 10, 6, 0, 16};
`ifdef SA_CTRL_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif

        // reset with both requesters pending: nothing may be granted
        rst = 1'b1; rsp_ready = 1'b0;
        scramble();
        req_valid = 2'b11;
        tick(); tick(); tick();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sa_rst", sa_rst, 1);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_s", rsp_s, 0);
        chk("rst_rsp_c", rsp_c, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_sa_a", sa_a, 0);
        rst = 1'b0; req_valid = 2'b00; m_last = 1;
        tick();
        chk("idle_sa_rst", sa_rst, 0);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].v[0]) txn(tbl[i].v, tbl[i].a, tbl[i].b, $urandom_range(0, 15), $urandom_range(0, 15),
                                 tbl[i].exp_sum, tbl[i].hold, id);
            else             txn(tbl[i].v, $urandom_range(0, 15), $urandom_range(0, 15), tbl[i].a, tbl[i].b,
                                 tbl[i].exp_sum, tbl[i].hold, id);
        end

        // contention from a fresh reset
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            txn(2'b11, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), -1, 0, id);
            chk("contention_id", id, exp_seq[i]);
        end

        // reset during the second RUN cycle aborts the transaction
        req_valid = 2'b01; req_a0 = 4'd6; req_b0 = 4'd7; rsp_ready = 1'b1;
        #1;
        chk("abort_accept", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        rst = 1'b1; req_valid = 2'b11;
        tick();
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sa_rst", sa_rst, 1);
        chk("abort_req_ready", req_ready, 0);
        rst = 1'b0; req_valid = 2'b00; m_last = 1;
        ok = 1'b1;
        for (int i = 0; i < LAT + 8; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("abort_no_rsp", ok, 1);
        txn(2'b10, 0, 0, 9, 4, 13, 0, id);

        // random traffic, random backpressure
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(1, 3);
            txn(2'(r), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), -1, $urandom_range(0, 3), id);
        end

        // exhaustive sweep, alternating requesters, back to back
        prev = 0; sp_ok = 1;
        for (int i = 0; i < 256; i++) begin
            int a, b;
            a = i / 16; b = i % 16;
            if (i % 2 == 0) txn(2'b01, a, b, 0, 0, a + b, 0, id);
            else            txn(2'b10, 0, 0, a, b, a + b, 0, id);
            if (i > 0 && acc_cyc - prev != LAT + 3) begin
                sp_ok = 0;
                $display("FAIL spacing: got %0d, expected %0d", acc_cyc - prev, LAT + 3);
            end
            prev = acc_cyc;
        end
        chk("sweep_spacing", sp_ok, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
